sdspi_arbiter: RTL and testbench
================================

// Module: sdspi_arbiter
// PURPOSE
// Shares one sdspihost instance between NUM_REQ requesters (e.g. fsm_autotest and a result logger).
// Owns the sdspihost reset and init sequence, then grants the host to one requester per session, round-robin.
// Muxes command strobes and address/data to the host. Steers busy/err/data_out back to the granted requester only.
// Sits between the requester FSMs and sdspihost inside the autotest top level.
// PARAMETERS
// NUM_REQ       2        number of requesters (2..8)
// RST_CYCLES    16       cycles spi_rst is held high per reset pulse
// INIT_TIMEOUT  2**24    cycles allowed for spi_busy to fall after reset before a retry
// PORTS
// clk            in   1          system clock
// rst            in   1          asynchronous, active-low reset
// req            in   NUM_REQ    session request per requester; held for the whole session
// gnt            out  NUM_REQ    one-hot session grant
// r_block        in   NUM_REQ    per-requester command strobes (same for r_multi_block, r_byte, w_block, w_byte)
// block_addr     in   NUM_REQ*32 per-requester block address, slice i = [32*i+:32]
// data_in        in   NUM_REQ*8  per-requester write byte
// busy           out  NUM_REQ    per-requester busy view
// err            out  NUM_REQ    per-requester error, sticky within a session
// data_out       out  8          host read byte, shared by all requesters
// spi_*          io   -          host side: spi_rst/strobes/block_addr/data_in out; spi_busy/spi_err/spi_data_out in
// ready          out  1          host initialised and available
// init_retries   out  8          saturating count of init timeouts
// BEHAVIOUR
// - Reset (rst=0): state INIT_RST, gnt=0, spi_rst=1, all spi strobes 0, busy=all 1s, err=0, ready=0, rr pointer=0, counters 0.
// - FSM states:
//   - INIT_RST: spi_rst=1 for RST_CYCLES cycles, then INIT_WAIT.
//   - INIT_WAIT: spi_rst=0. Wait for spi_busy=0. Then ready=1 and go to IDLE.
//     If spi_busy stays high for INIT_TIMEOUT cycles, increment init_retries and return to INIT_RST.
//     spi_err=1 in INIT_WAIT also returns to INIT_RST.
//   - IDLE: if any req, pick the first requester at or after the rr pointer. Registered: gnt[k]=1 on the next cycle, state GRANT.
//   - GRANT: requester k's strobes, block_addr and data_in reach spi_* combinationally (zero latency).
//     All other requesters' strobes are gated to 0.
//     busy[k]=spi_busy, busy[j!=k]=1, err[k] latches spi_err, data_out=spi_data_out.
//     If req[k]=0 and spi_busy=0, go to IDLE next cycle.
//     If req[k]=0 and spi_busy=1, go to DRAIN.
//   - DRAIN: strobes gated to 0. Wait for spi_busy=0, then IDLE.
//   - On leaving GRANT/DRAIN: gnt=0, rr pointer=k+1 mod NUM_REQ.
//     If an error occurred in the session, ready=0 and go to INIT_RST instead of IDLE (host re-init).
// - err[k] stays set until the grant ends. The requester must drop req to clear it.
// - Grant stability: gnt changes only on the IDLE->GRANT and GRANT/DRAIN->exit transitions. There is no pre-emption.
// - req rising in the same cycle as a release is not granted until the next IDLE cycle.
//   There is always at least one IDLE cycle between sessions.
// - Strobes from a requester arriving while it is not granted are dropped, not queued.
// - Reset mid-session: grant is revoked at once and the host is re-initialised.
// STRUCTURE
// - Package sdspi_arb_pkg: state_t enum {INIT_RST, INIT_WAIT, IDLE, GRANT, DRAIN}, spi_cmd_t struct of the five strobes, RST_CYCLES default.
// - Sub-module rr_picker: NUM_REQ-wide round-robin priority encoder. Inputs req and pointer; outputs one-hot grant and index.
// - Top: FSM, counters, output mux.
// TESTING
// - Reset release with the host model busy for 100 cycles: spi_rst high exactly 16 cycles, ready=1 one cycle after spi_busy falls.
// - req=2'b11 from IDLE, pointer 0: gnt=01. After release gnt=10 follows with exactly one IDLE cycle between.
// - Requester 1 pulses r_block while gnt=01: spi_r_block stays 0 and busy[1] stays 1.
// - Requester 0 drops req with spi_busy=1: state DRAIN, gnt=01 held until busy falls, then gnt=00.
// - spi_err during a session: err[0]=1 until req[0] drops, then spi_rst pulses again and ready=0 until re-init.
// - Host model never clears busy (INIT_TIMEOUT=64 in the bench): init_retries increments every 64+16 cycles and gnt stays 0.

Source files
------------

// File: rtl/sdspi_arbiter_pkg.sv
// sdspi_arb_pkg: shared state encoding, host command strobes and defaults for the sdspi arbiter.
package sdspi_arb_pkg;
    typedef enum logic [2:0] {INIT_RST, INIT_WAIT, IDLE, GRANT, DRAIN} state_t;
    typedef struct packed {
        logic r_block;
        logic r_multi_block;
        logic r_byte;
        logic w_block;
        logic w_byte;
    } spi_cmd_t;
    localparam int RST_CYCLES_DEF = 16;
endpackage

// File: rtl/sdspi_arbiter_if.sv
// sdspi_arbiter_if: requester-side and host-side buses of the sdspi arbiter.
interface sdspi_arbiter_if import sdspi_arb_pkg::*; #(parameter int NUM_REQ = 2);
    logic [NUM_REQ-1:0]    req, gnt, busy, err;
    logic [NUM_REQ-1:0]    r_block, r_multi_block, r_byte, w_block, w_byte;
    logic [NUM_REQ*32-1:0] block_addr;
    logic [NUM_REQ*8-1:0]  data_in;
    logic [7:0]            data_out;
    logic                  spi_rst, spi_busy, spi_err;
    spi_cmd_t              spi_cmd;
    logic [31:0]           spi_block_addr;
    logic [7:0]            spi_data_in, spi_data_out;
    modport slave (
        input  req, r_block, r_multi_block, r_byte, w_block, w_byte, block_addr, data_in,
        input  spi_busy, spi_err, spi_data_out,
        output gnt, busy, err, data_out, spi_rst, spi_cmd, spi_block_addr, spi_data_in
    );
    modport master (
        output req, r_block, r_multi_block, r_byte, w_block, w_byte, block_addr, data_in,
        output spi_busy, spi_err, spi_data_out,
        input  gnt, busy, err, data_out, spi_rst, spi_cmd, spi_block_addr, spi_data_in
    );
endinterface

// File: rtl/sdspi_arbiter_rr_picker.sv
// rr_picker: round-robin priority encoder, first request at or after ptr wins.
module rr_picker #(parameter int NUM_REQ = 2) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    localparam int PW = $clog2(NUM_REQ);
    always_comb begin
        int j;
        logic found;
        gnt = '0;
        idx = '0;
        found = 1'b0;
        j = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                gnt[j] = 1'b1;
                idx = PW'(j);
            end
        end
    end
endmodule

// File: rtl/sdspi_arbiter.sv
// sdspi_arbiter: owns sdspihost reset/init and grants the host to one requester per session, round-robin.
module sdspi_arbiter import sdspi_arb_pkg::*; #(
    parameter int NUM_REQ      = 2,
    parameter int RST_CYCLES   = RST_CYCLES_DEF,
    parameter int INIT_TIMEOUT = 2**24
) (
    input  logic            clk,
    input  logic            rst_n,
    sdspi_arbiter_if.slave  bus,
    output logic            ready,
    output logic [7:0]      init_retries
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2((INIT_TIMEOUT > RST_CYCLES ? INIT_TIMEOUT : RST_CYCLES) + 1);
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d, err_q, err_d, pick_gnt;
    logic [PW-1:0]      idx_q, idx_d, ptr_q, ptr_d, pick_idx;
    logic               ready_q, ready_d;
    logic [7:0]         retries_q, retries_d;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (.req(bus.req), .ptr(ptr_q), .gnt(pick_gnt), .idx(pick_idx));

    assign bus.gnt            = gnt_q;
    assign bus.err            = err_q;
    assign bus.busy           = ~gnt_q | {NUM_REQ{bus.spi_busy}};
    assign bus.data_out       = bus.spi_data_out;
    assign bus.spi_rst        = state_q == INIT_RST;
    assign bus.spi_block_addr = bus.block_addr[32*idx_q +: 32];
    assign bus.spi_data_in    = bus.data_in[8*idx_q +: 8];
    assign bus.spi_cmd        = state_q == GRANT ? spi_cmd_t'{bus.r_block[idx_q], bus.r_multi_block[idx_q],
                                bus.r_byte[idx_q], bus.w_block[idx_q], bus.w_byte[idx_q]} : '0;
    assign ready              = ready_q;
    assign init_retries       = retries_q;

    always_comb begin
        logic leave;
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        err_d     = err_q;
        ready_d   = ready_q;
        retries_d = retries_q;
        leave     = 1'b0;
        case (state_q)
            INIT_RST: begin
                cnt_d   = cnt_q == CW'(RST_CYCLES - 1) ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == CW'(RST_CYCLES - 1) ? INIT_WAIT : INIT_RST;
            end
            INIT_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.spi_err || (bus.spi_busy && cnt_q == CW'(INIT_TIMEOUT - 1))) begin
                    state_d = INIT_RST;
                    cnt_d   = '0;
                    if (!bus.spi_err && retries_q != 8'hff) retries_d = retries_q + 8'd1;
                end else if (!bus.spi_busy) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end
            end
            IDLE: begin
                if (|bus.req) begin
                    gnt_d   = pick_gnt;
                    idx_d   = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (bus.spi_err) err_d[idx_q] = 1'b1;
                if (!bus.req[idx_q]) begin
                    state_d = bus.spi_busy ? DRAIN : state_q;
                    leave   = !bus.spi_busy;
                end
            end
            DRAIN: begin
                if (bus.spi_err) err_d[idx_q] = 1'b1;
                leave = !bus.spi_busy;
            end
            default: state_d = INIT_RST;
        endcase
        // A session that saw an error hands back a host that must be re-initialised.
        if (leave) begin
            gnt_d   = '0;
            err_d   = '0;
            ptr_d   = idx_q == PW'(NUM_REQ - 1) ? '0 : idx_q + 1'b1;
            state_d = (|err_q || bus.spi_err) ? INIT_RST : IDLE;
            ready_d = !(|err_q || bus.spi_err);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= INIT_RST;
            cnt_q     <= '0;
            gnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            err_q     <= '0;
            ready_q   <= 1'b0;
            retries_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            retries_q <= retries_d;
        end
    end
endmodule

// File: tb/tb_sdspi_arbiter.sv
// tb_sdspi_arbiter: scoreboard bench for the sdspi arbiter with a behavioural sdspihost model.
module tb_sdspi_arbiter;
    import sdspi_arb_pkg::*;
    typedef struct {
        spi_cmd_t    cmd;
        logic [31:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       ready, t_ready, hold = 1'b0, to_done = 1'b0;
    logic [7:0] retries, t_retries;
    int         checks = 0, failures = 0, hcnt = 0;
    exp_t       sb[$];

    always #5 clk = ~clk;

    sdspi_arbiter_if #(.NUM_REQ(2)) b();
    sdspi_arbiter_if #(.NUM_REQ(2)) t();

    sdspi_arbiter #(.NUM_REQ(2), .RST_CYCLES(16), .INIT_TIMEOUT(256)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b), .ready(ready), .init_retries(retries));
    sdspi_arbiter #(.NUM_REQ(2), .RST_CYCLES(16), .INIT_TIMEOUT(64)) dut_to (
        .clk(clk), .rst_n(rst_n), .bus(t), .ready(t_ready), .init_retries(t_retries));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Host model: busy 100 cycles after its reset, 3 cycles after any command.
    always @(posedge clk) hcnt <= b.spi_rst ? 100 : |b.spi_cmd ? 3 : hcnt > 0 ? hcnt - 1 : 0;
    assign b.spi_busy = hcnt != 0 || hold;
    assign t.spi_busy = 1'b1;

    always @(negedge clk) begin
        if (rst_n && |b.spi_cmd) begin
            if (sb.size() == 0) check("unexpected_strobe", b.spi_cmd, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("cmd", b.spi_cmd, e.cmd);
                check("addr", b.spi_block_addr, e.addr);
                check("wdata", b.spi_data_in, e.data);
            end
        end
    end

    task automatic send_cmd(input int k, input int kind, input logic [31:0] a, input logic [7:0] d, input bit fwd);
        spi_cmd_t c;
        c = '0;
        case (kind)
            0: c.r_block = 1'b1;
            1: c.r_multi_block = 1'b1;
            2: c.r_byte = 1'b1;
            3: c.w_block = 1'b1;
            default: c.w_byte = 1'b1;
        endcase
        @(posedge clk); #1;
        b.block_addr[32*k +: 32] = a;
        b.data_in[8*k +: 8] = d;
        b.r_block[k] = c.r_block;
        b.r_multi_block[k] = c.r_multi_block;
        b.r_byte[k] = c.r_byte;
        b.w_block[k] = c.w_block;
        b.w_byte[k] = c.w_byte;
        if (fwd) sb.push_back('{c, a, d});
        @(negedge clk);
        if (!fwd) check("gated_strobe", b.spi_cmd, 0);
        @(posedge clk); #1;
        {b.r_block, b.r_multi_block, b.r_byte, b.w_block, b.w_byte} = '0;
    endtask

    task automatic wait_gnt(input logic [1:0] g, input string tag);
        int w;
        w = 0;
        while (b.gnt !== g && w < 10) begin
            @(negedge clk);
            w++;
        end
        check(tag, b.gnt, g);
    endtask

    task automatic wait_busy_low(input int k, input string tag);
        int w;
        w = 0;
        while (b.busy[k] !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check(tag, b.busy[k], 0);
    endtask

    initial begin
        @(posedge rst_n);
        repeat (79) @(posedge clk);
        @(negedge clk);
        check("to_retries_0", t_retries, 0);
        @(posedge clk);
        @(negedge clk);
        check("to_retries_1", t_retries, 1);
        check("to_gnt_1", t.gnt, 0);
        repeat (80) @(posedge clk);
        @(negedge clk);
        check("to_retries_2", t_retries, 2);
        check("to_gnt_2", t.gnt, 0);
        check("to_ready", t_ready, 0);
        to_done = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n, w;
        {b.req, b.r_block, b.r_multi_block, b.r_byte, b.w_block, b.w_byte} = '0;
        b.block_addr = '0; b.data_in = '0; b.spi_err = 1'b0; b.spi_data_out = 8'ha5;
        {t.r_block, t.r_multi_block, t.r_byte, t.w_block, t.w_byte} = '0;
        t.req = 2'b11; t.block_addr = '0; t.data_in = '0; t.spi_err = 1'b0; t.spi_data_out = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", b.gnt, 0);
        check("rst_spi_rst", b.spi_rst, 1);
        check("rst_cmd", b.spi_cmd, 0);
        check("rst_busy", b.busy, 2'b11);
        check("rst_err", b.err, 0);
        check("rst_ready", ready, 0);
        check("rst_retries", retries, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!b.spi_rst) break;
            n++;
        end
        check("spi_rst_len", n, 16);
        w = 0;
        while (b.spi_busy && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("init_busy_fall", b.spi_busy, 0);
        check("ready_at_fall", ready, 0);
        @(negedge clk);
        check("ready_after_fall", ready, 1);
        @(posedge clk); #1;
        b.req = 2'b11;
        @(negedge clk);
        @(negedge clk);
        check("gnt_first", b.gnt, 2'b01);
        check("busy_view", b.busy, 2'b10);
        check("data_out", b.data_out, 8'ha5);
        send_cmd(0, 0, 32'h1000_0010, 8'h11, 1'b1);
        send_cmd(1, 0, 32'h2000_0020, 8'h22, 1'b0);
        @(negedge clk);
        check("busy1_ungranted", b.busy[1], 1);
        wait_busy_low(0, "busy0_done");
        @(posedge clk); #1;
        b.req = 2'b10;
        @(negedge clk);
        @(negedge clk);
        check("idle_gap", b.gnt, 2'b00);
        @(negedge clk);
        check("gnt_second", b.gnt, 2'b10);
        send_cmd(1, 4, 32'h3000_0030, 8'h33, 1'b1);
        wait_busy_low(1, "busy1_done");
        @(posedge clk); #1;
        b.req = 2'b01;
        wait_gnt(2'b01, "gnt_third");
        @(posedge clk); #1;
        hold = 1'b1;
        send_cmd(0, 2, 32'h4000_0040, 8'h44, 1'b1);
        b.req = 2'b00;
        @(negedge clk);
        check("drain_busy0", b.busy[0], 1);
        send_cmd(0, 0, 32'h5000_0050, 8'h55, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("drain_hold", b.gnt, 2'b01);
        end
        @(posedge clk); #1;
        hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("drain_release", b.gnt, 2'b00);
        @(posedge clk); #1;
        b.req = 2'b01;
        wait_gnt(2'b01, "gnt_err_session");
        @(posedge clk); #1;
        b.spi_err = 1'b1;
        @(posedge clk); #1;
        b.spi_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("err_sticky", b.err, 2'b01);
        end
        check("ready_in_session", ready, 1);
        @(posedge clk); #1;
        b.req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("err_cleared", b.err, 0);
        check("err_gnt_revoked", b.gnt, 0);
        check("err_ready_low", ready, 0);
        check("err_spi_rst", b.spi_rst, 1);
        w = 0;
        while (!ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("reinit_ready", ready, 1);
        check("reinit_retries", retries, 0);
        w = 0;
        while (!to_done && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("timeout_bench_done", to_done, 1);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
